alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 42 ++++
 rtl/alu_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels between two requesters and the
// ALU arbiter. The requesters drive through the master modport. The arbiter
// receives through the slave modport. Both response channels share one
// result bus (rsp_s/rsp_cout).
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic        req0_cin;
  logic [1:0]  req0_op;

  logic        req1_valid;
  logic        req1_ready;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic        req1_cin;
  logic [1:0]  req1_op;

  logic        rsp0_valid;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [63:0] rsp_s;
  logic        rsp_cout;

  modport master (
    output req0_valid, req0_a, req0_b, req0_cin, req0_op,
    output req1_valid, req1_a, req1_b, req1_cin, req1_op,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_s, rsp_cout
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_cin, req0_op,
    input  req1_valid, req1_a, req1_b, req1_cin, req1_op,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_s, rsp_cout
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational 64-bit ALU between two
// requesters. An accepted request is latched, held on the ALU pins for
// SETTLE_CYCLES cycles, and then the ALU output is captured. The captured
// result is returned on the granted requester's response channel.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN. When it is defined, ties always
// go to requester 0. When it is not defined, ties are granted round-robin.
module alu_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 4   // legal range 1..255
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic [63:0]  alu_a,
  output logic [63:0]  alu_b,
  output logic         alu_cin,
  output logic [1:0]   alu_op,
  input  logic [63:0]  alu_s,
  input  logic         alu_cout,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gid_q, gid_d;      // requester currently being served
  logic        last_q, last_d;    // requester served most recently
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic        cin_q, cin_d;
  logic [1:0]  op_q, op_d;
  logic [63:0] s_q, s_d;
  logic        cout_q, cout_d;

  logic        grant_s;
  logic        rsp_ack_s;
  logic        req0_rdy_s;
  logic        req1_rdy_s;

  // Pick a requester for the IDLE state, and decode the response handshake of the served one.
  always_comb begin
    grant_s   = 1'b0;
    rsp_ack_s = gid_q ? bus.rsp1_ready : bus.rsp0_ready;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_s = 1'b0;
`else
      grant_s = ~last_q;
`endif
    end else if (bus.req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Next-state logic: accept, settle countdown, result capture, response handshake.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gid_d      = gid_q;
    last_d     = last_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    op_d       = op_q;
    s_d        = s_q;
    cout_d     = cout_q;
    req0_rdy_s = 1'b0;
    req1_rdy_s = 1'b0;
    case (state_q)
      IDLE: begin
        req0_rdy_s = bus.req0_valid && !grant_s;
        req1_rdy_s = bus.req1_valid && grant_s;
        if (req0_rdy_s || req1_rdy_s) begin
          gid_d   = grant_s;
          a_d     = grant_s ? bus.req1_a   : bus.req0_a;
          b_d     = grant_s ? bus.req1_b   : bus.req0_b;
          cin_d   = grant_s ? bus.req1_cin : bus.req0_cin;
          op_d    = grant_s ? bus.req1_op  : bus.req0_op;
          cnt_d   = SETTLE_INIT;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        if (cnt_q == 8'd0) begin
          s_d     = alu_s;
          cout_d  = alu_cout;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        if (rsp_ack_s) begin
          state_d = IDLE;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d  = gid_q;
`endif
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      a_q     <= 64'd0;
      b_q     <= 64'd0;
      cin_q   <= 1'b0;
      op_q    <= 2'd0;
      s_q     <= 64'd0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      op_q    <= op_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  // The ALU sees only latched operands, so its inputs stay stable while it settles.
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign alu_cin = cin_q;
  assign alu_op  = op_q;

  assign bus.req0_ready = req0_rdy_s;
  assign bus.req1_ready = req1_rdy_s;
  assign bus.rsp0_valid = (state_q == RESP) && !gid_q;
  assign bus.rsp1_valid = (state_q == RESP) && gid_q;
  assign bus.rsp_s      = s_q;
  assign bus.rsp_cout   = cout_q;
  assign busy           = (state_q != IDLE);

endmodule
